// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl
//
// Alarm-clock controller. Stores an alarm time, compares it against the
// running time code, and sequences the alarm through IDLE -> ARMED ->
// RINGING (and optionally SNOOZE) in response to one-cycle commands and a
// 1 Hz tick strobe.
//
// Optional feature:
//   ALARM_SNOOZE_EN  When defined, the SNOOZE state, the snooze period
//                    counter and the per-event snooze budget are built.
//                    When undefined, the snooze command has no effect and
//                    the state output never reads 2'b11.
//
// Parameters:
//   TW            width of time codes
//   RING_TIMEOUT  ticks after which an unanswered ring self-stops
//   SNOOZE_TICKS  ticks in one snooze period
//   MAX_SNOOZE    snoozes allowed per alarm event
//
// Ports:
//   clk         in   1   sole clock, rising edge
//   rst         in   1   synchronous active-high reset
//   tick        in   1   one-cycle 1 Hz strobe
//   cur_time    in   TW  current time code
//   set_time    in   TW  new alarm time, sampled on load
//   load        in   1   store set_time as the alarm time (IDLE/ARMED only)
//   arm         in   1   arm the alarm
//   disarm      in   1   disarm the alarm from any state
//   stop        in   1   silence the current alarm event, stay armed
//   snooze      in   1   postpone the ring by one snooze period
//   alarm_time  out  TW  stored alarm time, registered
//   armed       out  1   high in every state except IDLE, registered
//   ringing     out  1   high only in RINGING, registered
//   buzzer      out  1   buzzer drive, toggles per tick while ringing
//   state       out  2   IDLE=00, ARMED=01, RINGING=10, SNOOZE=11
// -----------------------------------------------------------------------------
module alarm_ctrl #(
    parameter int TW           = 12,
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_TICKS = 300,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic [TW-1:0] cur_time,
    input  logic [TW-1:0] set_time,
    input  logic          load,
    input  logic          arm,
    input  logic          disarm,
    input  logic          stop,
    input  logic          snooze,
    output logic [TW-1:0] alarm_time,
    output logic          armed,
    output logic          ringing,
    output logic          buzzer,
    output logic [1:0]    state
);

    // -------------------------------------------------------------------------
    // State encoding (fixed by the external state output)
    // -------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_ARMED   = 2'b01;
    localparam logic [1:0] S_RINGING = 2'b10;
    localparam logic [1:0] S_SNOOZE  = 2'b11;

    // The ring counter only ever holds 0..RING_TIMEOUT-1 because the tick
    // that would reach RING_TIMEOUT leaves RINGING instead of counting.
    localparam int              RING_W    = (RING_TIMEOUT > 1) ? $clog2(RING_TIMEOUT) : 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // Registers and internal wires
    // -------------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [TW-1:0]     r_alarm_time;
    logic              r_match_q;
    logic [RING_W-1:0] r_ring_cnt;
    logic              r_armed;
    logic              r_ringing;
    logic              r_buzzer;

    logic              w_match;
    logic              w_trigger;
    logic              w_ring_last;
    logic              w_snooze_ok;
    logic              w_snz_last;
    logic              w_state_change;
    logic [1:0]        w_next_state;

    // -------------------------------------------------------------------------
    // Time compare. The trigger is the rising edge of equality, so a time
    // that already equals the alarm when arming (or right after reset, when
    // match_q starts high) does not ring until equality is lost and regained.
    // -------------------------------------------------------------------------
    assign w_match     = (cur_time == r_alarm_time);
    assign w_trigger   = w_match && !r_match_q;
    assign w_ring_last = (r_ring_cnt == RING_LAST);

`ifdef ALARM_SNOOZE_EN
    // -------------------------------------------------------------------------
    // Snooze support: period counter and per-event snooze budget.
    // -------------------------------------------------------------------------
    localparam int                SNZ_W    = (SNOOZE_TICKS > 1) ? $clog2(SNOOZE_TICKS) : 1;
    localparam logic [SNZ_W-1:0]  SNZ_LAST = SNZ_W'(SNOOZE_TICKS - 1);
    // The budget counter must be able to hold MAX_SNOOZE itself.
    localparam int                USED_W   = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
    localparam logic [USED_W-1:0] USED_MAX = USED_W'(MAX_SNOOZE);

    logic [SNZ_W-1:0]  r_snz_cnt;
    logic [USED_W-1:0] r_snz_used;

    assign w_snooze_ok = snooze && (r_snz_used < USED_MAX);
    assign w_snz_last  = (r_snz_cnt == SNZ_LAST);
`else
    // Snooze is compiled out: the command and its sizing parameters are
    // accepted on the interface but have no effect.
    localparam int UNUSED_SNOOZE_CFG = SNOOZE_TICKS + MAX_SNOOZE;
    logic w_unused_snooze;

    assign w_unused_snooze = snooze;
    assign w_snooze_ok     = 1'b0;
    assign w_snz_last      = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state logic. Within each state the command priority is
    // disarm > stop > snooze > arm, and any command beats a coincident tick.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (arm) begin
                    w_next_state = S_ARMED;
                end
            end
            S_ARMED: begin
                // Disarm wins over a trigger in the same cycle.
                if (disarm) begin
                    w_next_state = S_IDLE;
                end else if (w_trigger) begin
                    w_next_state = S_RINGING;
                end
            end
            S_RINGING: begin
                if (disarm) begin
                    w_next_state = S_IDLE;
                end else if (stop) begin
                    w_next_state = S_ARMED;
                end else if (w_snooze_ok) begin
                    w_next_state = S_SNOOZE;
                end else if (tick && w_ring_last) begin
                    w_next_state = S_ARMED;
                end
            end
`ifdef ALARM_SNOOZE_EN
            S_SNOOZE: begin
                if (disarm) begin
                    w_next_state = S_IDLE;
                end else if (stop) begin
                    w_next_state = S_ARMED;
                end else if (tick && w_snz_last) begin
                    w_next_state = S_RINGING;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_state_change = (w_next_state != r_state);

    // -------------------------------------------------------------------------
    // Main sequential block: state, alarm time, compare history, ring
    // counter and registered status outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_alarm_time <= '0;
            r_match_q    <= 1'b1;
            r_ring_cnt   <= '0;
            r_armed      <= 1'b0;
            r_ringing    <= 1'b0;
            r_buzzer     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state   <= w_next_state;
            r_match_q <= w_match;

            // The alarm time is frozen while an alarm event is in progress.
            if (load && ((r_state == S_IDLE) || (r_state == S_ARMED))) begin
                r_alarm_time <= set_time;
            end

            // Ring counter restarts on every state entry; it only advances
            // on ticks that keep the FSM in RINGING, so it cannot wrap.
            if (w_state_change) begin
                r_ring_cnt <= '0;
            end else if ((r_state == S_RINGING) && tick) begin
                r_ring_cnt <= r_ring_cnt + 1'b1;
            end

            // Status outputs are computed from the next state so they line
            // up with the registered state output.
            r_armed   <= (w_next_state != S_IDLE);
            r_ringing <= (w_next_state == S_RINGING);

            // Buzzer: forced on when RINGING is entered, toggled by ticks
            // while RINGING persists, off everywhere else.
            if (w_next_state != S_RINGING) begin
                r_buzzer <= 1'b0;
            end else if (r_state != S_RINGING) begin
                r_buzzer <= 1'b1;
            end else if (tick) begin
                r_buzzer <= ~r_buzzer;
            end
        end
    end

`ifdef ALARM_SNOOZE_EN
    // -------------------------------------------------------------------------
    // Snooze counters.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_snz_cnt  <= '0;
            r_snz_used <= '0;
        end else begin
            // Period counter restarts on every state entry and only advances
            // on ticks that keep the FSM in SNOOZE.
            if (w_state_change) begin
                r_snz_cnt <= '0;
            end else if ((r_state == S_SNOOZE) && tick) begin
                r_snz_cnt <= r_snz_cnt + 1'b1;
            end

            // The budget belongs to one alarm event: it is refilled whenever
            // the event ends (entry to ARMED or IDLE) and spent per snooze.
            if (w_state_change &&
                ((w_next_state == S_ARMED) || (w_next_state == S_IDLE))) begin
                r_snz_used <= '0;
            end else if ((r_state == S_RINGING) && (w_next_state == S_SNOOZE)) begin
                r_snz_used <= r_snz_used + 1'b1;
            end
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign state      = r_state;
    assign alarm_time = r_alarm_time;
    assign armed      = r_armed;
    assign ringing    = r_ringing;
    assign buzzer     = r_buzzer;

endmodule
